// File: rtl/beep_seq_if.sv
// Note-push handshake for beep_seq.
//   in_valid : note offered by the producer
//   in_ready : sequencer FIFO can accept a note
//   in_half  : half-period in clock cycles (0 = rest)
//   in_dur   : note length in clock cycles (0 plays as 1)
// master = game control logic (producer), slave = beep_seq.
interface beep_seq_if #(
  parameter int unsigned HP_W  = 16,
  parameter int unsigned DUR_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [HP_W-1:0]  in_half;
  logic [DUR_W-1:0] in_dur;

  modport master (output in_valid, output in_half, output in_dur, input in_ready);
  modport slave  (input in_valid, input in_half, input in_dur, output in_ready);
endinterface

// File: rtl/beep_seq.sv
// Buzzer sequencer: queues notes (half-period, duration) in a small FIFO and
// plays them back-to-back as a square wave on beep.
//   clk, rst : clock, synchronous active-high reset
//   in_bus   : note push handshake (in_valid/in_ready/in_half/in_dur)
//   mute     : forces beep low without disturbing timing
//   flush    : empties the FIFO and aborts the current note
//   beep     : buzzer drive
//   busy     : high while a note is playing
//   level    : current FIFO occupancy
module beep_seq #(
  parameter int unsigned HP_W  = 16,
  parameter int unsigned DUR_W = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  beep_seq_if.slave                in_bus,
  input  logic                     mute,
  input  logic                     flush,
  output logic                     beep,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state;
  logic [HP_W-1:0]  half_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [HP_W-1:0]  cur_half;
  logic [DUR_W-1:0] cur_dur;
  logic [HP_W-1:0]  tone_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic             phase;

  logic             push;
  logic             pop;
  logic             end_note;
  logic [HP_W-1:0]  head_half;
  logic [DUR_W-1:0] head_dur;

  assign in_bus.in_ready = !rst && !flush && (level < FULL);
  assign busy = (state == PLAY);
  assign beep = phase && !mute;

  always_comb begin
    push      = in_bus.in_valid && in_bus.in_ready;
    end_note  = (state == PLAY) && (dur_cnt == cur_dur - DUR_W'(1));
    pop       = !flush && (level != '0) && ((state == IDLE) || end_note);
    head_half = half_mem[rd_ptr];
    head_dur  = dur_mem[rd_ptr];
    if (head_dur == '0) head_dur = DUR_W'(1);
  end

  // Note storage carries no reset; occupancy is tracked by level/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      half_mem[wr_ptr] <= in_bus.in_half;
      dur_mem[wr_ptr]  <= in_bus.in_dur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cur_half <= '0;
      cur_dur  <= '0;
      tone_cnt <= '0;
      dur_cnt  <= '0;
      phase    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (pop) begin
        // Loading also covers the gapless end-of-note reload. A rest starts
        // (and stays) silent, so its phase is loaded as 0 rather than 1.
        state    <= PLAY;
        cur_half <= head_half;
        cur_dur  <= head_dur;
        tone_cnt <= '0;
        dur_cnt  <= '0;
        phase    <= (head_half != '0);
      end else if (end_note) begin
        state    <= IDLE;
        tone_cnt <= '0;
        dur_cnt  <= '0;
        phase    <= 1'b0;
      end else if (state == PLAY) begin
        dur_cnt <= dur_cnt + DUR_W'(1);
        if (cur_half != '0) begin
          if (tone_cnt == cur_half - HP_W'(1)) begin
            phase    <= !phase;
            tone_cnt <= '0;
          end else begin
            tone_cnt <= tone_cnt + HP_W'(1);
          end
        end else begin
          phase <= 1'b0;
        end
      end else begin
        phase <= 1'b0;
      end
    end
  end

endmodule
